nd_1to2_router: RTL and testbench

- Single-input, two-output message router that sits between a message source and two message sinks, forwarding each message to one of them.
- Accepts messages on input channel i0 and routes each one to output o0 or o1 by comparing its destination address against a configurable compare / range test.
- Each output has a 2-entry FIFO, so one slow sink does not stall the other until that sink's FIFO is full.
- All channels use the codebase 4-phase req/ack protocol.

---
 rtl/nd_1to2_router.sv | 271 +++++++++++++++++++++++++++
 tb/tb_nd_1to2_router.sv | 378 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nd_1to2_router.sv
// nd_1to2_router: steers each message arriving on the i0 req/ack channel to
// sink o0 or o1 according to a compare (or range) test on its destination.
// Every output owns a 2-entry FIFO, so a slow sink only holds up the input
// once its own FIFO is full.

`ifndef NS_EQ_OP
`define NS_EQ_OP 0
`endif
`ifndef NS_NE_OP
`define NS_NE_OP 1
`endif
`ifndef NS_GT_OP
`define NS_GT_OP 2
`endif
`ifndef NS_GE_OP
`define NS_GE_OP 3
`endif
`ifndef NS_LT_OP
`define NS_LT_OP 4
`endif
`ifndef NS_LE_OP
`define NS_LE_OP 5
`endif
`ifndef NS_FALSE
`define NS_FALSE 0
`endif
`ifndef NS_TRUE
`define NS_TRUE 1
`endif
`ifndef NS_ADDRESS_SIZE
`define NS_ADDRESS_SIZE 8
`endif
`ifndef NS_DATA_SIZE
`define NS_DATA_SIZE 8
`endif

module nd_1to2_router #(
    parameter int OPER_1    = `NS_GT_OP,
    parameter int REF_VAL_1 = 0,
    parameter int IS_RANGE  = `NS_FALSE,
    parameter int OPER_2    = `NS_GT_OP,
    parameter int REF_VAL_2 = 0,
    parameter int ASZ       = `NS_ADDRESS_SIZE,
    parameter int DSZ       = `NS_DATA_SIZE
) (
    input  logic           i_clk,
    input  logic           reset,
    input  logic [ASZ-1:0] i0_src,
    input  logic [ASZ-1:0] i0_dst,
    input  logic [DSZ-1:0] i0_dat,
    input  logic           i0_req,
    output logic           i0_ack,
    output logic [ASZ-1:0] o0_src,
    output logic [ASZ-1:0] o0_dst,
    output logic [DSZ-1:0] o0_dat,
    output logic           o0_req,
    input  logic           o0_ack,
    output logic [ASZ-1:0] o1_src,
    output logic [ASZ-1:0] o1_dst,
    output logic [DSZ-1:0] o1_dat,
    output logic           o1_req,
    input  logic           o1_ack,
    output logic           o_busy
);

    localparam int MSZ = 2 * ASZ + DSZ;
    localparam logic [ASZ-1:0] REF_1 = ASZ'(REF_VAL_1);
    localparam logic [ASZ-1:0] REF_2 = ASZ'(REF_VAL_2);

    typedef enum logic {IN_IDLE, IN_ACK} in_state_t;

    in_state_t      in_state;
    in_state_t      in_next;
    logic           sel;
    logic           wr0;
    logic           wr1;
    logic           full0;
    logic           full1;
    logic           active0;
    logic           active1;
    logic [MSZ-1:0] msg0;
    logic [MSZ-1:0] msg1;

    function automatic logic compare(input int op, input logic [ASZ-1:0] a,
                                     input logic [ASZ-1:0] b);
        logic result;
        case (op)
            `NS_EQ_OP: result = (a == b);
            `NS_NE_OP: result = (a != b);
            `NS_GT_OP: result = (a > b);
            `NS_GE_OP: result = (a >= b);
            `NS_LT_OP: result = (a < b);
            `NS_LE_OP: result = (a <= b);
            default:   result = 1'b0;
        endcase
        return result;
    endfunction

    // In range mode the destination must satisfy both compares
    assign sel = (IS_RANGE != `NS_FALSE) ?
                 (compare(OPER_1, i0_dst, REF_1) && compare(OPER_2, i0_dst, REF_2)) :
                 compare(OPER_1, i0_dst, REF_1);

    // Input handshake state register
    always_ff @(posedge i_clk or negedge reset) begin
        if (!reset) begin
            in_state <= IN_IDLE;
        end else begin
            in_state <= in_next;
        end
    end

    // Accept only into the FIFO the message routes to; a full target blocks the input
    always_comb begin
        in_next = in_state;
        wr0     = 1'b0;
        wr1     = 1'b0;
        case (in_state)
            IN_IDLE: begin
                if (i0_req && !(sel ? full1 : full0)) begin
                    wr0     = !sel;
                    wr1     = sel;
                    in_next = IN_ACK;
                end
            end
            IN_ACK: begin
                if (!i0_req) begin
                    in_next = IN_IDLE;
                end
            end
            default: in_next = IN_IDLE;
        endcase
    end

    assign i0_ack = (in_state == IN_ACK);

    nd_router_port #(.MSZ(MSZ)) port0 (
        .i_clk  (i_clk),
        .reset  (reset),
        .wr     (wr0),
        .wr_msg ({i0_src, i0_dst, i0_dat}),
        .ack    (o0_ack),
        .full   (full0),
        .req    (o0_req),
        .msg    (msg0),
        .active (active0)
    );

    nd_router_port #(.MSZ(MSZ)) port1 (
        .i_clk  (i_clk),
        .reset  (reset),
        .wr     (wr1),
        .wr_msg ({i0_src, i0_dst, i0_dat}),
        .ack    (o1_ack),
        .full   (full1),
        .req    (o1_req),
        .msg    (msg1),
        .active (active1)
    );

    assign {o0_src, o0_dst, o0_dat} = msg0;
    assign {o1_src, o1_dst, o1_dat} = msg1;

    // Busy flag is registered so it never glitches on the combinational decode
    always_ff @(posedge i_clk or negedge reset) begin
        if (!reset) begin
            o_busy <= 1'b0;
        end else begin
            o_busy <= active0 | active1 | i0_ack | o0_req | o1_req;
        end
    end

endmodule

// nd_router_port: one output of the router, a 2-entry FIFO feeding a
// req/ack sender. The head entry stays in the FIFO until the sink acks it.
module nd_router_port #(
    parameter int MSZ = 24
) (
    input  logic           i_clk,
    input  logic           reset,
    input  logic           wr,
    input  logic [MSZ-1:0] wr_msg,
    input  logic           ack,
    output logic           full,
    output logic           req,
    output logic [MSZ-1:0] msg,
    output logic           active
);

    typedef enum logic [1:0] {OUT_IDLE, OUT_REQ, OUT_WAIT} out_state_t;

    out_state_t     state;
    out_state_t     state_next;
    logic [MSZ-1:0] mem [2];
    logic           wr_ptr;
    logic           rd_ptr;
    logic [1:0]     count;
    logic           pop;
    logic           load;

    assign full   = (count == 2'd2);
    assign active = (count != 2'd0) || (state != OUT_IDLE);

    // Sender sequencing: present head, wait for ack, then wait for ack release
    always_comb begin
        state_next = state;
        pop        = 1'b0;
        load       = 1'b0;
        case (state)
            OUT_IDLE: begin
                if (count != 2'd0) begin
                    load       = 1'b1;
                    state_next = OUT_REQ;
                end
            end
            OUT_REQ: begin
                if (ack) begin
                    pop        = 1'b1;
                    state_next = OUT_WAIT;
                end
            end
            OUT_WAIT: begin
                if (!ack) begin
                    state_next = OUT_IDLE;
                end
            end
            default: state_next = OUT_IDLE;
        endcase
    end

    // Sender registers; the message holds its last value while idle
    always_ff @(posedge i_clk or negedge reset) begin
        if (!reset) begin
            state <= OUT_IDLE;
            req   <= 1'b0;
            msg   <= '0;
        end else begin
            state <= state_next;
            req   <= (state_next == OUT_REQ);
            if (load) begin
                msg <= mem[rd_ptr];
            end
        end
    end

    // FIFO storage and bookkeeping; a simultaneous write and pop leaves count alone
    always_ff @(posedge i_clk or negedge reset) begin
        if (!reset) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (wr) begin
                mem[wr_ptr] <= wr_msg;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({wr, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_nd_1to2_router.sv
// Bench for nd_1to2_router: two instances (single compare and range compare)
// driven by a req/ack source and req/ack sinks, scored against per-sink
// queues of expected messages routed by a plain model of the compare rule.
`timescale 1ns/1ps
module tb_nd_1to2_router;

    localparam int ASZ = 8;
    localparam int DSZ = 8;
    localparam int MSZ = 2 * ASZ + DSZ;
    // Operator codes understood by the router's compare parameters
    localparam int OP_GT = 2;
    localparam int OP_LT = 4;

    logic           i_clk = 1'b0;
    logic           reset = 1'b0;
    logic [ASZ-1:0] in_src [2];
    logic [ASZ-1:0] in_dst [2];
    logic [DSZ-1:0] in_dat [2];
    logic           in_req [2];
    logic           in_ack [2];
    logic           busy [2];
    logic [ASZ-1:0] out_src [4];
    logic [ASZ-1:0] out_dst [4];
    logic [DSZ-1:0] out_dat [4];
    logic           out_req [4];
    logic           out_ack [4];

    logic [MSZ-1:0] expq [4][$];
    int             pops [4];
    logic [DSZ-1:0] last_dat [4];
    int             hold [4];
    int             dly [4];
    int             wait_cnt [4];
    bit             rand_dly = 1'b0;
    int             compared = 0;
    int             mismatched = 0;

    always #5 i_clk = ~i_clk;

    // Channel 0/1 are o0/o1 of dut_a, channel 2/3 are o0/o1 of dut_b
    nd_1to2_router #(.OPER_1(OP_GT), .REF_VAL_1(1), .IS_RANGE(0), .OPER_2(OP_GT),
                     .REF_VAL_2(0), .ASZ(ASZ), .DSZ(DSZ)) dut_a (
        .i_clk(i_clk), .reset(reset),
        .i0_src(in_src[0]), .i0_dst(in_dst[0]), .i0_dat(in_dat[0]),
        .i0_req(in_req[0]), .i0_ack(in_ack[0]),
        .o0_src(out_src[0]), .o0_dst(out_dst[0]), .o0_dat(out_dat[0]),
        .o0_req(out_req[0]), .o0_ack(out_ack[0]),
        .o1_src(out_src[1]), .o1_dst(out_dst[1]), .o1_dat(out_dat[1]),
        .o1_req(out_req[1]), .o1_ack(out_ack[1]),
        .o_busy(busy[0])
    );

    nd_1to2_router #(.OPER_1(OP_GT), .REF_VAL_1(2), .IS_RANGE(1), .OPER_2(OP_LT),
                     .REF_VAL_2(5), .ASZ(ASZ), .DSZ(DSZ)) dut_b (
        .i_clk(i_clk), .reset(reset),
        .i0_src(in_src[1]), .i0_dst(in_dst[1]), .i0_dat(in_dat[1]),
        .i0_req(in_req[1]), .i0_ack(in_ack[1]),
        .o0_src(out_src[2]), .o0_dst(out_dst[2]), .o0_dat(out_dat[2]),
        .o0_req(out_req[2]), .o0_ack(out_ack[2]),
        .o1_src(out_src[3]), .o1_dst(out_dst[3]), .o1_dat(out_dat[3]),
        .o1_req(out_req[3]), .o1_ack(out_ack[3]),
        .o_busy(busy[1])
    );

    // Routing rule of each instance stated directly in numbers
    function automatic int route(input int d, input logic [ASZ-1:0] dst);
        int v;
        v = int'(dst);
        if (d == 0) return (v > 1) ? 1 : 0;
        return (v > 2 && v < 5) ? 1 : 0;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, actual, expected);
        end
    endtask

    task automatic start_msg(input int d, input logic [ASZ-1:0] src,
                             input logic [ASZ-1:0] dst, input logic [DSZ-1:0] dat);
        in_src[d] = src;
        in_dst[d] = dst;
        in_dat[d] = dat;
        in_req[d] = 1'b1;
        expq[d * 2 + route(d, dst)].push_back({src, dst, dat});
    endtask

    task automatic finish_msg(input int d);
        int n;
        n = 0;
        while (!in_ack[d] && n < 400) begin
            @(posedge i_clk);
            #1;
            n++;
        end
        if (!in_ack[d]) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL input_ack_timeout dut%0d: got ack=0, required ack=1 within 400 cycles", d);
        end
        in_req[d] = 1'b0;
        n = 0;
        while (in_ack[d] && n < 10) begin
            @(posedge i_clk);
            #1;
            n++;
        end
        if (in_ack[d]) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL input_ack_release dut%0d: got ack=1, required ack=0 within 10 cycles", d);
        end
    endtask

    task automatic applyStimulus(input int d, input logic [ASZ-1:0] src,
                                 input logic [ASZ-1:0] dst, input logic [DSZ-1:0] dat);
        start_msg(d, src, dst, dat);
        finish_msg(d);
    endtask

    task automatic wait_drain(input string name);
        bit empty;
        empty = 1'b0;
        for (int n = 0; n < 2000; n++) begin
            empty = 1'b1;
            for (int c = 0; c < 4; c++) begin
                if (expq[c].size() != 0) empty = 1'b0;
            end
            if (empty) break;
            @(posedge i_clk);
            #1;
        end
        if (!empty) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL %s_drain: got undelivered messages, required all delivered in 2000 cycles", name);
        end
        repeat (4) @(posedge i_clk);
        #1;
        checkOutput({name, "_busy_a"}, busy[0], 0);
        checkOutput({name, "_busy_b"}, busy[1], 0);
    endtask

    // Sinks: ack a request after a (possibly random) delay unless held off
    always begin
        @(posedge i_clk);
        #1;
        for (int c = 0; c < 4; c++) begin
            if (!reset) begin
                out_ack[c]  = 1'b0;
                wait_cnt[c] = 0;
            end else if (out_ack[c]) begin
                if (!out_req[c]) out_ack[c] = 1'b0;
            end else if (out_req[c] && hold[c] == 0) begin
                if (wait_cnt[c] >= dly[c]) begin
                    out_ack[c]  = 1'b1;
                    wait_cnt[c] = 0;
                    if (rand_dly) dly[c] = $urandom_range(0, 5);
                end else begin
                    wait_cnt[c]++;
                end
            end
        end
    end

    // Every presented message must be the oldest one the model still owes that sink
    always @(negedge i_clk) begin
        if (reset) begin
            for (int c = 0; c < 4; c++) begin
                if (out_req[c]) begin
                    compared++;
                    if (expq[c].size() == 0) begin
                        mismatched++;
                        $display("[TB] FAIL unexpected_req ch%0d: got req with dat 0x%0h, required no request",
                                 c, out_dat[c]);
                    end else if ({out_src[c], out_dst[c], out_dat[c]} !== expq[c][0]) begin
                        mismatched++;
                        $display("[TB] FAIL out_msg ch%0d: got 0x%0h, required 0x%0h",
                                 c, {out_src[c], out_dst[c], out_dat[c]}, expq[c][0]);
                    end
                    if (out_ack[c] && expq[c].size() != 0) begin
                        last_dat[c] = out_dat[c];
                        pops[c]++;
                        void'(expq[c].pop_front());
                    end
                end
            end
        end
    end

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: got no finish, required finish within 5 ms");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int base0;
        int base1;
        int exp0;
        int exp1;
        logic [ASZ-1:0] rdst;

        for (int c = 0; c < 4; c++) begin
            out_ack[c]  = 1'b0;
            hold[c]     = 0;
            dly[c]      = 1;
            wait_cnt[c] = 0;
            last_dat[c] = '0;
            pops[c]     = 0;
        end
        for (int d = 0; d < 2; d++) begin
            in_req[d] = 1'b0;
            in_src[d] = '0;
            in_dst[d] = '0;
            in_dat[d] = '0;
        end

        // Reset state
        repeat (3) @(posedge i_clk);
        #1;
        checkOutput("rst_i0_ack", in_ack[0], 0);
        checkOutput("rst_o0_req", out_req[0], 0);
        checkOutput("rst_o1_req", out_req[1], 0);
        checkOutput("rst_busy", busy[0], 0);
        checkOutput("rst_o1_dat", out_dat[1], 0);
        checkOutput("rst_b_o0_dst", out_dst[2], 0);
        reset = 1'b1;
        @(posedge i_clk);
        #1;

        // Basic routing and latency
        start_msg(0, 8'h11, 8'd1, 8'd3);
        @(posedge i_clk);
        #1;
        checkOutput("t1_ack_after_1_edge", in_ack[0], 1);
        checkOutput("t1_req_not_yet", out_req[0], 0);
        @(posedge i_clk);
        #1;
        checkOutput("t1_req_after_2_edges", out_req[0], 1);
        checkOutput("t1_o0_dat", out_dat[0], 3);
        finish_msg(0);
        applyStimulus(0, 8'h22, 8'd2, 8'd4);
        wait_drain("t1");
        checkOutput("t1_o0_count", pops[0], 1);
        checkOutput("t1_o1_count", pops[1], 1);
        checkOutput("t1_o0_last", last_dat[0], 3);
        checkOutput("t1_o1_last", last_dat[1], 4);
        checkOutput("t1_o1_dst_held", out_dst[1], 2);

        // Full FIFO blocks the input
        hold[1] = 1;
        applyStimulus(0, 8'h30, 8'd2, 8'd0);
        applyStimulus(0, 8'h31, 8'd2, 8'd1);
        start_msg(0, 8'h32, 8'd2, 8'd2);
        repeat (6) @(posedge i_clk);
        #1;
        checkOutput("t2_third_stalled", in_ack[0], 0);
        checkOutput("t2_o1_req_held", out_req[1], 1);
        checkOutput("t2_o1_head", out_dat[1], 0);
        checkOutput("t2_o1_none_popped", pops[1], 1);
        hold[1] = 0;
        finish_msg(0);
        wait_drain("t2");
        checkOutput("t2_o1_count", pops[1], 4);
        checkOutput("t2_o1_last", last_dat[1], 2);

        // Alternating destinations with random sink delays
        rand_dly = 1'b1;
        base0 = pops[0];
        base1 = pops[1];
        for (int i = 0; i < 16; i++) begin
            int gap;
            applyStimulus(0, ASZ'($urandom), (i % 2 == 0) ? 8'd1 : 8'd2, DSZ'(i / 2));
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) begin
                @(posedge i_clk);
                #1;
            end
        end
        wait_drain("t3");
        checkOutput("t3_o0_count", pops[0] - base0, 8);
        checkOutput("t3_o1_count", pops[1] - base1, 8);
        checkOutput("t3_o0_last", last_dat[0], 7);
        checkOutput("t3_o1_last", last_dat[1], 7);

        // Random destinations and data
        base0 = pops[0];
        base1 = pops[1];
        exp0 = 0;
        exp1 = 0;
        for (int i = 0; i < 24; i++) begin
            rdst = ASZ'($urandom_range(0, 7));
            if (route(0, rdst) == 1) exp1++;
            else exp0++;
            applyStimulus(0, ASZ'($urandom), rdst, DSZ'($urandom));
        end
        wait_drain("t3r");
        checkOutput("t3r_o0_count", pops[0] - base0, exp0);
        checkOutput("t3r_o1_count", pops[1] - base1, exp1);
        rand_dly = 1'b0;
        for (int c = 0; c < 4; c++) dly[c] = 1;

        // Asynchronous reset during an active request
        hold[0] = 1;
        applyStimulus(0, 8'h40, 8'd1, 8'hA0);
        applyStimulus(0, 8'h41, 8'd0, 8'hA1);
        @(posedge i_clk);
        #1;
        checkOutput("t4_o0_req_before", out_req[0], 1);
        #2;
        reset = 1'b0;
        #1;
        checkOutput("t4_o0_req_async", out_req[0], 0);
        checkOutput("t4_i0_ack_async", in_ack[0], 0);
        checkOutput("t4_o0_dat_cleared", out_dat[0], 0);
        checkOutput("t4_busy_cleared", busy[0], 0);
        for (int c = 0; c < 4; c++) expq[c].delete();
        hold[0] = 0;
        @(posedge i_clk);
        #1;
        reset = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(posedge i_clk);
            #1;
            checkOutput("t4_o0_req_quiet", out_req[0], 0);
        end
        checkOutput("t4_i0_ack_quiet", in_ack[0], 0);
        applyStimulus(0, 8'h42, 8'd1, 8'hB0);
        wait_drain("t4");
        checkOutput("t4_new_msg", last_dat[0], 8'hB0);

        // Range compare on the second instance
        applyStimulus(1, 8'h50, 8'd3, 8'd1);
        applyStimulus(1, 8'h51, 8'd5, 8'd2);
        applyStimulus(1, 8'h52, 8'd2, 8'd3);
        wait_drain("t5");
        checkOutput("t5_o1_count", pops[3], 1);
        checkOutput("t5_o0_count", pops[2], 2);
        checkOutput("t5_o1_last", last_dat[3], 1);
        checkOutput("t5_o0_last", last_dat[2], 3);

        // Both outputs stalled, then released in the same cycle
        hold[0] = 1;
        hold[1] = 1;
        dly[0]  = 0;
        dly[1]  = 0;
        applyStimulus(0, 8'h60, 8'd1, 8'hC0);
        applyStimulus(0, 8'h61, 8'd2, 8'hC1);
        applyStimulus(0, 8'h62, 8'd1, 8'hC2);
        applyStimulus(0, 8'h63, 8'd2, 8'hC3);
        base0 = pops[0];
        base1 = pops[1];
        @(posedge i_clk);
        #1;
        checkOutput("t6_o0_req_stalled", out_req[0], 1);
        checkOutput("t6_o1_req_stalled", out_req[1], 1);
        hold[0] = 0;
        hold[1] = 0;
        @(posedge i_clk);
        @(posedge i_clk);
        #2;
        checkOutput("t6_o0_req_dropped", out_req[0], 0);
        checkOutput("t6_o1_req_dropped", out_req[1], 0);
        checkOutput("t6_o0_one_pop", pops[0] - base0, 1);
        checkOutput("t6_o1_one_pop", pops[1] - base1, 1);
        wait_drain("t6");
        checkOutput("t6_o0_last", last_dat[0], 8'hC2);
        checkOutput("t6_o1_last", last_dat[1], 8'hC3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
